// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: locks onto HEADER, assembles speed/corner/X0 big-endian and commits them atomically.
// Define UART_FRAME_CSUM_EN to append and verify a trailing XOR checksum byte.
module uart_frame_assembler #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         SPEED_W     = 32,
    parameter int         CORNER_W    = 20,
    parameter int         TIMEOUT_CYC = 112500
) (
    input  logic                CLK_I,
    input  logic                RST_N_I,
    input  logic                RX_VLD_I,
    input  logic [7:0]          RX_D_I,
    output logic [SPEED_W-1:0]  SPEED_O,
    output logic [CORNER_W-1:0] CORNER_O,
    output logic [7:0]          X0_O,
    output logic                FRAME_VLD_O,
    output logic                FRAME_ERR_O,
    output logic                BUSY_O
);
    localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef UART_FRAME_CSUM_EN
    typedef enum logic [2:0] {IDLE, SPEED, CORNER, XB, CSUM, COMMIT} state_e;
`else
    typedef enum logic [2:0] {IDLE, SPEED, CORNER, XB, COMMIT} state_e;
`endif
    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TW-1:0]       to_q, to_d;
    logic [SPEED_W-1:0]  speed_sh_q, speed_sh_d, speed_q;
    logic [31:0]         corner_sh_q, corner_sh_d;
    logic [7:0]          x0_sh_q, x0_sh_d, x0_q;
    logic [CORNER_W-1:0] corner_q;
    logic                vld_q, err_q, busy_q;
    logic                in_frame, commit, tmo, ok, csum_ok;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0] csum_q, csum_d;
    // Payload bytes and the checksum byte XOR to zero on a good frame.
    always_comb csum_d = (state_q == IDLE || state_q == COMMIT) ? 8'h00 : RX_VLD_I ? csum_q ^ RX_D_I : csum_q;
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) csum_q <= 8'h00;
        else csum_q <= csum_d;
    end
    assign csum_ok = (csum_q == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif
    assign in_frame = (state_q != IDLE) && (state_q != COMMIT);
    assign commit   = (state_q == COMMIT);
    assign ok       = ((corner_sh_q >> CORNER_W) == 32'd0) && csum_ok;
    assign tmo      = in_frame && !RX_VLD_I && (to_q == TW'(TIMEOUT_CYC - 1));
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        speed_sh_d  = speed_sh_q;
        corner_sh_d = corner_sh_q;
        x0_sh_d     = x0_sh_q;
        to_d        = (in_frame && !RX_VLD_I) ? to_q + 1'b1 : '0;
        case (state_q)
            SPEED: if (RX_VLD_I) begin
                speed_sh_d = {speed_sh_q[SPEED_W-9:0], RX_D_I};
                cnt_d      = cnt_q + 2'd1;
                state_d    = (cnt_q == 2'd3) ? CORNER : SPEED;
            end
            CORNER: if (RX_VLD_I) begin
                corner_sh_d = {corner_sh_q[23:0], RX_D_I};
                cnt_d       = cnt_q + 2'd1;
                state_d     = (cnt_q == 2'd3) ? XB : CORNER;
            end
            XB: if (RX_VLD_I) begin
                x0_sh_d = RX_D_I;
`ifdef UART_FRAME_CSUM_EN
                state_d = CSUM;
`else
                state_d = COMMIT;
`endif
            end
`ifdef UART_FRAME_CSUM_EN
            CSUM: if (RX_VLD_I) state_d = COMMIT;
`endif
            // IDLE and COMMIT both listen for a header, giving back-to-back frames.
            default: begin
                cnt_d   = 2'd0;
                state_d = (RX_VLD_I && RX_D_I == HEADER) ? SPEED : IDLE;
            end
        endcase
        if (tmo) state_d = IDLE;
    end
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            speed_sh_q  <= '0;
            corner_sh_q <= '0;
            x0_sh_q     <= '0;
            speed_q     <= '0;
            corner_q    <= '0;
            x0_q        <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            speed_sh_q  <= speed_sh_d;
            corner_sh_q <= corner_sh_d;
            x0_sh_q     <= x0_sh_d;
            vld_q       <= commit && ok;
            err_q       <= (commit && !ok) || tmo;
            busy_q      <= (state_d != IDLE);
            if (commit && ok) begin
                speed_q  <= speed_sh_q;
                corner_q <= corner_sh_q[CORNER_W-1:0];
                x0_q     <= x0_sh_q;
            end
        end
    end
    assign SPEED_O     = speed_q;
    assign CORNER_O    = corner_q;
    assign X0_O        = x0_q;
    assign FRAME_VLD_O = vld_q;
    assign FRAME_ERR_O = err_q;
    assign BUSY_O      = busy_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb_uart_frame_assembler: table-driven frames, directed corner cases and random traffic against a byte-queue model.
module tb_uart_frame_assembler;
    localparam int T  = 16;
    localparam int CW = 20;
`ifdef UART_FRAME_CSUM_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 9;
`endif
    logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
    logic [7:0] d = 8'h00;
    logic [31:0] speed;
    logic [CW-1:0] corner;
    logic [7:0] x0;
    logic fvld, ferr, busy;
    int n_chk = 0, n_fail = 0, n_vldp = 0, n_errp = 0;
    logic [31:0] m_speed;
    logic [CW-1:0] m_corner;
    logic [7:0] m_x0;
    bit m_vld, m_err, m_in, m_pend;
    int m_idle;
    logic [7:0] mq[$];
    typedef struct {
        logic [15:0] pre;
        int          npre;
        logic [71:0] p;
        logic [31:0] sp;
        logic [CW-1:0] co;
        logic [7:0]  x0;
        bit          v;
    } vec_t;
    vec_t tv[7];

    uart_frame_assembler #(.HEADER(8'hA5), .SPEED_W(32), .CORNER_W(CW), .TIMEOUT_CYC(T)) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .RX_VLD_I(vld), .RX_D_I(d),
        .SPEED_O(speed), .CORNER_O(corner), .X0_O(x0),
        .FRAME_VLD_O(fvld), .FRAME_ERR_O(ferr), .BUSY_O(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_speed = '0; m_corner = '0; m_x0 = '0;
        m_vld = 0; m_err = 0; m_in = 0; m_pend = 0; m_idle = 0;
        mq.delete();
    endtask

    // Frame rules applied to the collected byte list: bytes 0-3 speed, 4-7 corner, 8 X0, optional 9 checksum.
    task automatic model_step(input bit v, input logic [7:0] b);
        logic [31:0] c32;
        logic [7:0] x;
        bit good;
        m_vld = 0;
        m_err = 0;
        if (m_pend) begin
            c32 = {mq[4], mq[5], mq[6], mq[7]};
            x = 8'h00;
            for (int i = 0; i < 9; i++) x ^= mq[i];
            good = (64'(c32) < (64'd1 << CW)) && (FLEN == 9 || x == mq[FLEN-1]);
            if (good) begin
                m_speed  = {mq[0], mq[1], mq[2], mq[3]};
                m_corner = c32[CW-1:0];
                m_x0     = mq[8];
                m_vld    = 1;
            end else m_err = 1;
            m_pend = 0;
        end
        if (m_in) begin
            if (v) begin
                mq.push_back(b);
                m_idle = 0;
                if (mq.size() == FLEN) begin
                    m_in = 0;
                    m_pend = 1;
                end
            end else if (m_idle == T - 1) begin
                m_in = 0;
                m_err = 1;
            end else m_idle++;
        end else if (v && b == 8'hA5) begin
            m_in = 1;
            m_idle = 0;
            mq.delete();
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] b);
        vld = v;
        d = b;
        @(posedge clk);
        model_step(v, b);
        #1;
        vld = 1'b0;
        if (fvld) n_vldp++;
        if (ferr) n_errp++;
        chk("cycle_model", {speed, corner, x0, fvld, ferr, busy},
            {m_speed, m_corner, m_x0, m_vld, m_err, m_in || m_pend});
    endtask

    task automatic send_payload(input logic [71:0] p, input bit with_sum, input logic [7:0] sum_xor);
        logic [7:0] x;
        x = 8'h00;
        cycle(1, 8'hA5);
        for (int i = 0; i < 9; i++) begin
            cycle(1, p[71-8*i -: 8]);
            x ^= p[71-8*i -: 8];
        end
        if (with_sum && FLEN == 10) cycle(1, x ^ sum_xor);
    endtask

    task automatic send_vec(input int i);
        for (int j = 0; j < tv[i].npre; j++) cycle(1, tv[i].pre[15-8*j -: 8]);
        send_payload(tv[i].p, 1, 8'h00);
        cycle(0, 8'h00);
        chk($sformatf("tv%0d_vld", i), fvld, tv[i].v);
        chk($sformatf("tv%0d_err", i), ferr, !tv[i].v);
        chk($sformatf("tv%0d_out", i), {speed, corner, x0}, {tv[i].sp, tv[i].co, tv[i].x0});
    endtask

    task automatic rand_test();
        logic [7:0] bs[$];
        logic [7:0] x, b;
        for (int it = 0; it < 80; it++) begin
            bs.delete();
            if ($urandom_range(0, 3) == 0) bs.push_back(8'($urandom));
            bs.push_back(8'hA5);
            x = 8'h00;
            for (int i = 0; i < 9; i++) begin
                b = 8'($urandom);
                if (i == 4 && $urandom_range(0, 3) != 0) b = 8'h00;
                if (i == 5 && $urandom_range(0, 3) != 0) b &= 8'h0F;
                bs.push_back(b);
                x ^= b;
            end
            if (FLEN == 10) bs.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom) : x);
            foreach (bs[i]) begin
                repeat (($urandom_range(0, 29) == 0) ? T + 1 : $urandom_range(0, 2)) cycle(0, 8'h00);
                cycle(1, bs[i]);
            end
        end
        repeat (T + 4) cycle(0, 8'h00);
    endtask

    initial begin
        int k_err, e0, v0;
        tv[0] = '{16'h0000, 0, 72'h00_00_01_F4_00_00_80_00_32, 32'h000001F4, 20'h08000, 8'h32, 1'b1};
        tv[1] = '{16'h1377, 2, 72'h00_00_01_F4_00_00_80_00_32, 32'h000001F4, 20'h08000, 8'h32, 1'b1};
        tv[2] = '{16'h0000, 0, 72'hA5_00_00_01_00_00_80_00_32, 32'hA5000001, 20'h08000, 8'h32, 1'b1};
        tv[3] = '{16'h0000, 0, 72'h00_00_00_07_00_10_00_00_11, 32'hA5000001, 20'h08000, 8'h32, 1'b0};
        tv[4] = '{16'h0000, 0, 72'h12_34_56_78_00_0F_FF_FF_FF, 32'h12345678, 20'hFFFFF, 8'hFF, 1'b1};
        tv[5] = '{16'h0000, 0, 72'h01_02_03_04_80_00_00_00_05, 32'h12345678, 20'hFFFFF, 8'hFF, 1'b0};
        tv[6] = '{16'h0000, 0, 72'hFF_FF_FF_FF_00_0A_5A_5A_A5, 32'hFFFFFFFF, 20'hA5A5A, 8'hA5, 1'b1};
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", {speed, corner, x0, fvld, ferr, busy}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send_vec(i);
        // Timeout: error exactly T idle cycles after the last byte, then recovery.
        cycle(1, 8'hA5); cycle(1, 8'h00); cycle(1, 8'h00);
        k_err = 0;
        for (int k = 1; k <= 3 * T && k_err == 0; k++) begin
            cycle(0, 8'h00);
            if (ferr) k_err = k;
        end
        chk("timeout_latency", k_err, T);
        chk("timeout_busy", busy, 1'b0);
        send_vec(0);
        // A byte landing in the expiry cycle is accepted.
        e0 = n_errp;
        cycle(1, 8'hA5); cycle(1, tv[4].p[71:64]);
        repeat (T - 1) cycle(0, 8'h00);
        for (int i = 1; i < 9; i++) cycle(1, tv[4].p[71-8*i -: 8]);
        if (FLEN == 10) cycle(1, 8'h00 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h0F ^ 8'hFF ^ 8'hFF ^ 8'hFF ^ 8'h12);
        cycle(0, 8'h00);
        chk("expiry_vld", fvld, 1'b1);
        chk("expiry_noerr", n_errp - e0, 0);
        // Reset mid-frame.
        cycle(1, 8'hA5); cycle(1, 8'h12); cycle(1, 8'h34);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {speed, corner, x0, fvld, ferr, busy}, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_vec(4);
        // Back-to-back frames, second header in the commit cycle.
        v0 = n_vldp;
        send_payload(tv[0].p, 1, 8'h00);
        send_payload(tv[4].p, 1, 8'h00);
        cycle(0, 8'h00);
        chk("b2b_pulses", n_vldp - v0, 2);
        chk("b2b_out", {speed, corner, x0}, {tv[4].sp, tv[4].co, tv[4].x0});
`ifdef UART_FRAME_CSUM_EN
        send_payload(tv[0].p, 0, 8'h00);
        cycle(1, 8'h00);
        cycle(0, 8'h00);
        chk("csum_bad_vld", fvld, 1'b0);
        chk("csum_bad_err", ferr, 1'b1);
        chk("csum_bad_out", {speed, corner, x0}, {tv[4].sp, tv[4].co, tv[4].x0});
`endif
        rand_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
